delay_line_scheduler: RTL

//  Synthesisable, clocked replacement for behavioural #-delay modelling. Samples a 1-bit

---
 rtl/delay_pkg.sv | 23 ++
 rtl/event_fifo.sv | 80 ++++++++
 rtl/delay_line_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// Shared constants and helpers for the clocked delay line: mode encodings,
// minimum delay and the per-cycle scheduling action.
package delay_pkg;

  localparam logic MODE_TRANSPORT = 1'b0;
  localparam logic MODE_INERTIAL  = 1'b1;

  localparam int unsigned MIN_DELAY = 1;

  // What the scheduler does with the transition seen this cycle.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_PUSH   = 2'd1,
    EV_CANCEL = 2'd2,
    EV_DROP   = 2'd3
  } ev_action_e;

  // A zero delay would schedule an event for the current cycle, which can never match.
  function automatic int unsigned clamp_delay(input int unsigned d);
    return (d < MIN_DELAY) ? MIN_DELAY : d;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of due timestamps with an extra tail-pop used to cancel the
// most recently scheduled event. Head is read combinationally from registers.
module event_fifo
  import delay_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     pop_tail,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg,  count_next;
  logic          push_ok, pop_ok, tail_ok;
  logic [W-1:0]  entries [DEPTH];

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Tail cancel only when nothing else touches the queue this cycle.
  assign tail_ok = pop_tail && !empty && !push_ok && !pop_ok;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= din;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign head = entries[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end else if (tail_ok) begin
      wr_ptr_next = wr_ptr_reg - AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok) - (AW+1)'(tail_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/delay_line_scheduler.sv
// Cycle-accurate programmable delay line: timestamps each input transition and
// toggles y when the free-running counter reaches the transition's due time.
module delay_line_scheduler
  import delay_pkg::*;
#(
  parameter int CW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a,
  input  logic [CW-1:0]            delay_cfg,
  input  logic                     inertial,
  input  logic                     clr_ovf,
  output logic                     y,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     ovf
);

  logic [CW-1:0] cnt_reg;
  logic          a_q_reg;
  logic          y_reg, y_next;
  logic          ovf_reg, ovf_next;

  logic [CW-1:0] eff_delay;
  logic [CW-1:0] due;
  logic          trans;
  logic          release_ev;
  ev_action_e    action;

  logic [CW-1:0]            head;
  logic                     fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;

  assign eff_delay = CW'(clamp_delay(32'(delay_cfg)));
  // Modulo arithmetic; equality compare on release keeps it correct across wrap.
  assign due        = cnt_reg + eff_delay;
  assign trans      = (a != a_q_reg);
  assign release_ev = !fifo_empty && (head == cnt_reg);

  always_comb begin
    action = EV_NONE;
    if (trans) begin
      if ((inertial == MODE_INERTIAL) && !fifo_empty && !release_ev) begin
        // Pulse shorter than the delay: retract the pending edge, y never moves.
        action = EV_CANCEL;
      end else if (fifo_full) begin
        action = EV_DROP;
      end else begin
        action = EV_PUSH;
      end
    end
  end

  event_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (action == EV_PUSH),
    .din      (due),
    .pop      (release_ev),
    .pop_tail (action == EV_CANCEL),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    y_next   = release_ev ? ~y_reg : y_reg;
    ovf_next = ovf_reg;
    if (action == EV_DROP) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      a_q_reg <= 1'b0;
      y_reg   <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
      a_q_reg <= a;
      y_reg   <= y_next;
      ovf_reg <= ovf_next;
    end
  end

  assign y       = y_reg;
  assign ovf     = ovf_reg;
  assign pending = fifo_count;
  assign busy    = (fifo_count != '0);

endmodule
